ifetch_queue: RTL and testbench
===============================

IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, queue entries; legal values 2, 4 or 8.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port mem_req  output  1  instruction-RAM read request.
REQ-006 SHALL have port mem_addr  output  32  word-aligned byte address for mem_req.
REQ-007 SHALL have port mem_rdata  input  32  read data, valid exactly 1 cycle after mem_req.
REQ-008 SHALL have port ins_valid  output  1  queue head holds an instruction.
REQ-009 SHALL have port ins_data  output  32  head instruction word.
REQ-010 SHALL have port ins_pc  output  32  head instruction address.
REQ-011 SHALL have port ins_ready  input  1  core consumes head when ins_valid && ins_ready.
REQ-012 SHALL have port redirect  input  1  branch/jump/trap flush request.
REQ-013 SHALL have port redirect_pc  input  32  new fetch address; bits [1:0] ignored.
REQ-014 SHALL have port halt  input  1  stop issuing new fetches.

Function
REQ-015 SHALL implement FSM states RUN, STOP; RUN->STOP when halt=1, STOP->RUN when halt=0.
REQ-016 SHALL assert mem_req in RUN only when occupancy + in-flight < DEPTH and redirect=0.
REQ-017 SHALL drive mem_addr = fetch_pc; fetch_pc += 4 on each cycle with mem_req=1, wrapping modulo 2^32.
REQ-018 SHALL write mem_rdata plus its address into the tail one cycle after the request; no bypass, so ins_valid rises 2 cycles after mem_req.
REQ-019 SHALL present ins_data/ins_pc from the head, stable while ins_valid && !ins_ready.
REQ-020 SHALL allow one push and one pop in the same cycle when full or empty without loss or duplication.
REQ-021 SHALL on redirect: empty the queue, set fetch_pc = {redirect_pc[31:2],2'b00}, discard any in-flight response, and deassert mem_req that cycle.
REQ-022 SHALL drive ins_valid=0 in the cycle after redirect; the pop in a redirect cycle is treated as discarded.
REQ-023 SHALL issue the first post-redirect request in the cycle after redirect.
REQ-024 SHALL in STOP still accept the in-flight response and allow draining; redirect in STOP updates fetch_pc only.
REQ-025 SHALL never overflow: in-flight + occupancy <= DEPTH at all times.

Reset
REQ-026 SHALL, with resetn=0, asynchronously force: state=RUN, fetch_pc=RESET_PC, occupancy=0, in-flight=0, mem_req=0, ins_valid=0, ins_data=0, ins_pc=0, mem_addr=RESET_PC.
REQ-027 SHALL issue the first mem_req at RESET_PC in the first rising edge cycle after resetn deasserts.
REQ-028 SHALL discard any response pending when reset asserts mid-operation.

Structure
REQ-029 SHALL take XLEN=32, the instruction-word typedef and the RESET_PC default from shared package rv_pkg.
REQ-030 SHALL place storage and pointers in sub-module ifq_fifo (parameterised DEPTH, synchronous flush); control and FSM stay in ifetch_queue.

Verification
REQ-031 Reset release, RAM word i = 32'h1000_0000+i, ins_ready=1 -> mem_addr 0,4,8,... one per cycle; ins_valid high from cycle 2; ins_pc/ins_data 0/1000_0000, 4/1000_0001 in order.
REQ-032 ins_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 requests issued, mem_req low thereafter, head stays pc 0; release -> pcs 0,4,8,12,16 without gaps or repeats.
REQ-033 redirect with redirect_pc=32'h0000_0103 while 2 entries queued plus 1 in flight -> next cycle ins_valid=0, next mem_addr=32'h100, the stale response never appears at ins_*.
REQ-034 halt=1 with queue half full -> no new mem_req, in-flight word still enqueued, queue drains to ins_valid=0; halt=0 -> fetching resumes at next sequential pc.
REQ-035 redirect_pc=32'hFFFF_FFFC, ins_ready=1 -> mem_addr FFFF_FFFC then 0000_0000; ins_pc values match.
REQ-036 resetn pulsed low mid-stream with full queue -> all outputs at reset values same cycle; restart fetches from RESET_PC, no pre-reset words delivered.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV32 definitions for the instruction-fetch front end: word widths,
// the fetch queue entry layout and the fetch controller states.
package rv_pkg;

    localparam int XLEN = 32;

    typedef logic [XLEN-1:0] word_t;
    typedef word_t           insn_t;

    localparam word_t RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        word_t pc;
        insn_t insn;
    } ifq_entry_t;

    typedef enum logic {
        RUN  = 1'b0,
        STOP = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/ifq_fifo.sv
// Circular buffer holding fetched {pc, instruction} pairs, with a synchronous
// flush used by the fetch controller on redirects. DEPTH must be 2, 4 or 8.
module ifq_fifo
    import rv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     flush,
    input  logic                     push,
    input  ifq_entry_t               push_entry,
    input  logic                     pop,
    output ifq_entry_t               head_entry,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    ifq_entry_t       mem_q [DEPTH];
    ifq_entry_t       mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full;
    logic             do_push;
    logic             do_pop;

    // A push into a full buffer is only accepted when the head leaves in the same cycle.
    always_comb begin
        full     = (count_q == CNT_W'(DEPTH));
        empty    = (count_q == '0);
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_entry;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_entry = mem_q[rd_ptr_q];
    assign count      = count_q;

endmodule

// File: rtl/ifetch_queue.sv
// Instruction prefetch queue: issues sequential reads to a 1-cycle instruction
// RAM, buffers the returned words and hands them to the core in order.
module ifetch_queue
    import rv_pkg::*;
#(
    parameter int    DEPTH    = 4,
    parameter word_t RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            resetn,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            ins_valid,
    output logic [XLEN-1:0] ins_data,
    output logic [XLEN-1:0] ins_pc,
    input  logic            ins_ready,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            halt
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int SUM_W = CNT_W + 1;

    fetch_state_t     state_q, state_d;
    word_t            fetch_pc_q, fetch_pc_d;
    word_t            inflight_pc_q, inflight_pc_d;
    logic             inflight_q, inflight_d;
    logic             live_q, live_d;
    logic [CNT_W-1:0] occupancy;
    logic [SUM_W-1:0] committed;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    ifq_entry_t       push_entry;
    ifq_entry_t       head_entry;

    // live_q keeps mem_req low while reset is held and for the release cycle, so
    // the first request lands in the cycle after the first post-reset edge.
    always_comb begin
        state_d         = halt ? STOP : RUN;
        committed       = {1'b0, occupancy} + SUM_W'(inflight_q);
        mem_req         = live_q && (state_q == RUN) && !redirect
                          && (committed < SUM_W'(DEPTH));
        push            = inflight_q && !redirect;
        pop             = !fifo_empty && ins_ready && !redirect;
        push_entry.pc   = inflight_pc_q;
        push_entry.insn = mem_rdata;
        inflight_d      = mem_req;
        inflight_pc_d   = fetch_pc_q;
        live_d          = 1'b1;
        fetch_pc_d      = fetch_pc_q;
        if (redirect) begin
            fetch_pc_d = redirect_pc & ~word_t'(3);
        end else if (mem_req) begin
            fetch_pc_d = fetch_pc_q + word_t'(4);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= RUN;
            fetch_pc_q    <= RESET_PC;
            inflight_pc_q <= '0;
            inflight_q    <= 1'b0;
            live_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            inflight_pc_q <= inflight_pc_d;
            inflight_q    <= inflight_d;
            live_q        <= live_d;
        end
    end

    ifq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .resetn     (resetn),
        .flush      (redirect),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head_entry (head_entry),
        .empty      (fifo_empty),
        .count      (occupancy)
    );

    assign mem_addr  = fetch_pc_q;
    assign ins_valid = !fifo_empty;
    assign ins_data  = head_entry.insn;
    assign ins_pc    = head_entry.pc;

endmodule

// File: tb/tb_ifetch_queue.sv
// Randomised self-checking bench for ifetch_queue against a queue-based
// behavioural model plus directed scenarios for streaming, stalls and redirects.
module tb_ifetch_queue;
    import rv_pkg::*;

    localparam int    DEPTH    = 4;
    localparam word_t RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata = '0;
    logic        ins_valid;
    logic [31:0] ins_data;
    logic [31:0] ins_pc;
    logic        ins_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        halt = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_q [$];
    bit          m_inflight;
    logic [31:0] m_inflight_pc;
    logic [31:0] m_fetch_pc;
    bit          m_halted;
    bit          m_live;

    bit          e_valid;
    bit          e_req;
    logic [31:0] e_pc;
    logic [31:0] e_data;
    logic [31:0] e_addr;

    always #5 clk = ~clk;

    ifetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .ins_valid   (ins_valid),
        .ins_data    (ins_data),
        .ins_pc      (ins_pc),
        .ins_ready   (ins_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt)
    );

    function automatic logic [31:0] ram_word(input logic [31:0] addr);
        return 32'h1000_0000 + (addr >> 2);
    endfunction

    // Instruction RAM: data for a request appears during the following cycle; garbage otherwise.
    always @(posedge clk) begin
        mem_rdata <= mem_req ? ram_word(mem_addr) : $urandom;
    end

    task automatic model_reset();
        m_q.delete();
        m_inflight    = 1'b0;
        m_inflight_pc = '0;
        m_fetch_pc    = RESET_PC;
        m_halted      = 1'b0;
        m_live        = 1'b0;
    endtask

    task automatic predict();
        e_valid = (m_q.size() != 0);
        e_pc    = e_valid ? m_q[0] : 32'h0;
        e_data  = e_valid ? ram_word(m_q[0]) : 32'h0;
        e_req   = m_live && !m_halted && !redirect
                  && ((m_q.size() + int'(m_inflight)) < DEPTH);
        e_addr  = m_fetch_pc;
    endtask

    task automatic model_edge();
        if (redirect) begin
            m_q.delete();
            m_inflight = 1'b0;
            m_fetch_pc = redirect_pc & 32'hFFFF_FFFC;
        end else begin
            if (m_q.size() != 0 && ins_ready) void'(m_q.pop_front());
            if (m_inflight) m_q.push_back(m_inflight_pc);
            m_inflight    = e_req;
            m_inflight_pc = m_fetch_pc;
            if (e_req) m_fetch_pc = m_fetch_pc + 32'd4;
        end
        m_halted = halt;
        m_live   = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0; ins_ready = 1'b0; redirect = 1'b0; halt = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        #1 predict();
        @(posedge clk);
        model_edge();
    endtask

    task automatic test_reset();
        model_reset();
        @(negedge clk);
        #1;
        checks++;
        if (mem_req !== 1'b0 || ins_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctl req=%b valid=%b, want 0/0", mem_req, ins_valid);
        end
        checks++;
        if (ins_data !== 32'h0 || ins_pc !== 32'h0 || mem_addr !== RESET_PC) begin
            errors++;
            $display("[TB] FAIL reset_data data=%h pc=%h addr=%h, want 0/0/%h",
                     ins_data, ins_pc, mem_addr, RESET_PC);
        end
    endtask

    task automatic test_stream();
        do_reset();
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            ins_ready = 1'b1;
            #1 predict();
            checks++;
            if (ins_valid !== e_valid) begin
                errors++; $display("[TB] FAIL stream_valid got %b want %b", ins_valid, e_valid);
            end
            if (e_valid) begin
                checks++;
                if (ins_pc !== e_pc || ins_data !== e_data) begin
                    errors++;
                    $display("[TB] FAIL stream_head got %h/%h want %h/%h", ins_pc, ins_data, e_pc, e_data);
                end
            end
            checks++;
            if (mem_req !== e_req || mem_addr !== e_addr) begin
                errors++;
                $display("[TB] FAIL stream_req got %b/%h want %b/%h", mem_req, mem_addr, e_req, e_addr);
            end
            checks++;
            if (mem_req !== 1'b1 || mem_addr !== 32'(4 * c)) begin
                errors++;
                $display("[TB] FAIL stream_addr got %b/%h want 1/%h", mem_req, mem_addr, 32'(4 * c));
            end
            if (c >= 2) begin
                checks++;
                if (ins_valid !== 1'b1 || ins_pc !== 32'(4 * (c - 2))
                    || ins_data !== 32'h1000_0000 + 32'(c - 2)) begin
                    errors++;
                    $display("[TB] FAIL stream_order got %b %h/%h want 1 %h/%h", ins_valid, ins_pc,
                             ins_data, 32'(4 * (c - 2)), 32'h1000_0000 + 32'(c - 2));
                end
            end
            @(posedge clk);
            model_edge();
        end
    endtask

    task automatic test_backpressure();
        int          reqs = 0;
        int          pops = 0;
        logic [31:0] next_pc = 32'h0;
        do_reset();
        for (int c = 0; c < 22; c++) begin
            @(negedge clk);
            ins_ready = (c >= 10);
            #1 predict();
            checks++;
            if (ins_valid !== e_valid || mem_req !== e_req || mem_addr !== e_addr) begin
                errors++;
                $display("[TB] FAIL bp_model got v%b r%b %h want v%b r%b %h",
                         ins_valid, mem_req, mem_addr, e_valid, e_req, e_addr);
            end
            if (c < 10 && mem_req === 1'b1) reqs++;
            if (c >= 3 && c < 10) begin
                checks++;
                if (ins_valid !== 1'b1 || ins_pc !== 32'h0) begin
                    errors++; $display("[TB] FAIL bp_head got %b/%h want 1/0", ins_valid, ins_pc);
                end
            end
            if (c >= 10 && ins_valid === 1'b1) begin
                checks++;
                if (ins_pc !== next_pc || ins_data !== ram_word(next_pc)) begin
                    errors++;
                    $display("[TB] FAIL bp_drain got %h/%h want %h/%h", ins_pc, ins_data, next_pc, ram_word(next_pc));
                end
                next_pc = next_pc + 32'd4;
                pops++;
            end
            @(posedge clk);
            model_edge();
        end
        checks++;
        if (reqs !== 4) begin
            errors++; $display("[TB] FAIL bp_reqs got %0d want 4", reqs);
        end
        checks++;
        if (pops < 10) begin
            errors++; $display("[TB] FAIL bp_gapless got %0d pops want >= 10", pops);
        end
    endtask

    task automatic test_redirect();
        do_reset();
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            ins_ready   = (c >= 5);
            redirect    = (c == 3);
            redirect_pc = 32'h0000_0103;
            #1 predict();
            checks++;
            if (ins_valid !== e_valid || mem_req !== e_req || mem_addr !== e_addr
                || (e_valid && (ins_pc !== e_pc || ins_data !== e_data))) begin
                errors++;
                $display("[TB] FAIL redir_model got v%b %h r%b %h want v%b %h r%b %h",
                         ins_valid, ins_pc, mem_req, mem_addr, e_valid, e_pc, e_req, e_addr);
            end
            if (c == 3) begin
                checks++;
                if (mem_req !== 1'b0 || ins_valid !== 1'b1 || ins_pc !== 32'h0) begin
                    errors++;
                    $display("[TB] FAIL redir_cycle got r%b v%b pc %h want r0 v1 pc 0", mem_req, ins_valid, ins_pc);
                end
            end
            if (c == 4) begin
                checks++;
                if (ins_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h100) begin
                    errors++;
                    $display("[TB] FAIL redir_next got v%b r%b %h want v0 r1 00000100", ins_valid, mem_req, mem_addr);
                end
            end
            if (c >= 4 && ins_valid === 1'b1) begin
                checks++;
                if (ins_pc < 32'h100) begin
                    errors++; $display("[TB] FAIL redir_stale got pc %h want >= 00000100", ins_pc);
                end
            end
            @(posedge clk);
            model_edge();
        end
        redirect = 1'b0;
    endtask

    task automatic test_halt();
        logic [31:0] last_addr = 32'h0;
        bit          resumed = 1'b0;
        do_reset();
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            ins_ready = (c >= 6);
            halt      = (c >= 3 && c < 14);
            #1 predict();
            checks++;
            if (ins_valid !== e_valid || mem_req !== e_req || mem_addr !== e_addr
                || (e_valid && (ins_pc !== e_pc || ins_data !== e_data))) begin
                errors++;
                $display("[TB] FAIL halt_model got v%b %h r%b %h want v%b %h r%b %h",
                         ins_valid, ins_pc, mem_req, mem_addr, e_valid, e_pc, e_req, e_addr);
            end
            if (c >= 4 && c < 15) begin
                checks++;
                if (mem_req !== 1'b0) begin
                    errors++; $display("[TB] FAIL halt_noreq cycle %0d got req %b want 0", c, mem_req);
                end
            end
            if (c == 13) begin
                checks++;
                if (ins_valid !== 1'b0) begin
                    errors++; $display("[TB] FAIL halt_drain got valid %b want 0", ins_valid);
                end
            end
            if (c < 14 && mem_req === 1'b1) last_addr = mem_addr;
            if (c >= 14 && mem_req === 1'b1 && !resumed) begin
                resumed = 1'b1;
                checks++;
                if (mem_addr !== last_addr + 32'd4) begin
                    errors++; $display("[TB] FAIL halt_resume_pc got %h want %h", mem_addr, last_addr + 32'd4);
                end
            end
            @(posedge clk);
            model_edge();
        end
        checks++;
        if (!resumed) begin
            errors++; $display("[TB] FAIL halt_resume got no request want one");
        end
    endtask

    task automatic test_wrap();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            halt        = 1'b0;
            ins_ready   = 1'b1;
            redirect    = (c == 0);
            redirect_pc = 32'hFFFF_FFFC;
            #1 predict();
            checks++;
            if (ins_valid !== e_valid || mem_req !== e_req || mem_addr !== e_addr
                || (e_valid && (ins_pc !== e_pc || ins_data !== e_data))) begin
                errors++;
                $display("[TB] FAIL wrap_model got v%b %h r%b %h want v%b %h r%b %h",
                         ins_valid, ins_pc, mem_req, mem_addr, e_valid, e_pc, e_req, e_addr);
            end
            if (c == 1 || c == 2) begin
                checks++;
                if (mem_req !== 1'b1 || mem_addr !== (c == 1 ? 32'hFFFF_FFFC : 32'h0)) begin
                    errors++; $display("[TB] FAIL wrap_addr cycle %0d got %b/%h", c, mem_req, mem_addr);
                end
            end
            if (c == 3 || c == 4) begin
                checks++;
                if (ins_valid !== 1'b1 || ins_pc !== (c == 3 ? 32'hFFFF_FFFC : 32'h0)) begin
                    errors++; $display("[TB] FAIL wrap_pc cycle %0d got %b/%h", c, ins_valid, ins_pc);
                end
            end
            @(posedge clk);
            model_edge();
        end
        redirect = 1'b0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            ins_ready   = ($urandom_range(3) != 0);
            halt        = ($urandom_range(7) == 0);
            redirect    = ($urandom_range(15) == 0);
            redirect_pc = $urandom;
            #1 predict();
            checks++;
            if (ins_valid !== e_valid || mem_req !== e_req || mem_addr !== e_addr
                || (e_valid && (ins_pc !== e_pc || ins_data !== e_data))) begin
                errors++;
                $display("[TB] FAIL random_model cycle %0d got v%b %h/%h r%b %h want v%b %h/%h r%b %h", c,
                         ins_valid, ins_pc, ins_data, mem_req, mem_addr, e_valid, e_pc, e_data, e_req, e_addr);
            end
            @(posedge clk);
            model_edge();
        end
    endtask

    task automatic test_midreset();
        bit first_seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            ins_ready = 1'b0; halt = 1'b0; redirect = 1'b0;
            #1 predict();
            @(posedge clk);
            model_edge();
        end
        @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || ins_valid !== 1'b0 || ins_data !== 32'h0
            || ins_pc !== 32'h0 || mem_addr !== RESET_PC) begin
            errors++;
            $display("[TB] FAIL midreset_outs got r%b v%b %h/%h addr %h want r0 v0 0/0 addr %h",
                     mem_req, ins_valid, ins_data, ins_pc, mem_addr, RESET_PC);
        end
        model_reset();
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        #1 predict();
        @(posedge clk);
        model_edge();
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            ins_ready = 1'b1;
            #1 predict();
            checks++;
            if (ins_valid !== e_valid || mem_req !== e_req || mem_addr !== e_addr
                || (e_valid && (ins_pc !== e_pc || ins_data !== e_data))) begin
                errors++;
                $display("[TB] FAIL midreset_model got v%b %h r%b %h want v%b %h r%b %h",
                         ins_valid, ins_pc, mem_req, mem_addr, e_valid, e_pc, e_req, e_addr);
            end
            if (ins_valid === 1'b1 && !first_seen) begin
                first_seen = 1'b1;
                checks++;
                if (ins_pc !== RESET_PC) begin
                    errors++; $display("[TB] FAIL midreset_first got pc %h want %h", ins_pc, RESET_PC);
                end
            end
            @(posedge clk);
            model_edge();
        end
        checks++;
        if (!first_seen) begin
            errors++; $display("[TB] FAIL midreset_restart got no instruction want one");
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_halt();
        test_wrap();
        test_random();
        test_midreset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
